bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Two-master arbiter that shares the single core-side memory bus (`bus_req_*` / `bus_resp_*`) between the vscale core data port (master 0) and the AXI-Lite bus bridge (master 1). It has one transaction in flight at a time and registers the winning request. It forwards that request downstream, routes the response back to the owning master, and returns an error response if the downstream slave does not answer within a programmable limit.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum cycles spent in RESP before an error response is returned; 0 disables the timeout.
- `S_AXI_ACLK`  in  1  clock; the only clock.
- `S_AXI_ARESETN`  in  1  asynchronous, active-low reset.
- `mN_req_valid`  in  1  master N (N = 0, 1) has a request.
- `mN_req_ready`  out  1  request from master N accepted this cycle.
- `mN_req_addr`  in  32  byte address.
- `mN_req_wen`  in  1  1 = write, 0 = read.
- `mN_req_wmask`  in  4  byte write strobes.
- `mN_req_data`  in  32  write data.
- `mN_resp_valid`  out  1  one-cycle response pulse to master N.
- `mN_resp_data`  out  32  read data; 0 for writes and errors.
- `mN_resp_err`  out  1  response is a timeout error.
- `bus_req_valid`  out  1  downstream request valid.
- `bus_req_ready`  in  1  downstream accepts the request.
- `bus_req_addr`, `bus_req_wen`, `bus_req_wmask`, `bus_req_data`  out  32/1/4/32  registered request fields.
- `bus_resp_valid`  in  1  downstream response valid.
- `bus_resp_data`  in  32  downstream read data.

## Operation
- The FSM has three states: IDLE, REQ and RESP. Encoding is IDLE=0, REQ=1, RESP=2.
- **IDLE:** the arbiter picks a winner among the valid masters.
  - When both masters are valid, the winner is the master that was not granted last.
  - `last_grant` resets to 1, so master 0 wins the first contention.
  - `mW_req_ready` is asserted combinationally for the winner only; the loser sees ready=0.
  - On accept, the arbiter latches the request fields and `owner`=W, then moves to REQ.
- **REQ:** `bus_req_valid`=1 with the latched fields held stable.
  - On `bus_req_ready`=1: move to RESP and clear the timeout counter.
- **RESP:** the arbiter waits for `bus_resp_valid`.
  - On `bus_resp_valid`=1: pulse `m[owner]_resp_valid` with `resp_data`=`bus_resp_data` and `resp_err`=0. Set `last_grant`=owner and return to IDLE.
  - Otherwise the counter increments. If `TIMEOUT_CYCLES`≠0 and the counter reaches `TIMEOUT_CYCLES`, pulse `m[owner]_resp_valid` with `resp_err`=1 and data=0. Set `last_grant`=owner and return to IDLE.
  - If `bus_resp_valid` and the timeout occur in the same cycle, the real response wins.
- `bus_resp_valid` is ignored in IDLE and REQ. A late response after a timeout is dropped.
- Response outputs are registered. The non-owner always sees `resp_valid`=0.
- The timeout counter is `$clog2(TIMEOUT_CYCLES+1)` bits wide and saturates. It is never compared when `TIMEOUT_CYCLES`=0.
- **Reset (asynchronous, any state):**
  - FSM returns to IDLE.
  - All outputs go to 0: `bus_req_valid`, `bus_req_*`, `mN_req_ready`, `mN_resp_valid`, `mN_resp_data`, `mN_resp_err`.
  - `last_grant`=1, counter=0.
  - An in-flight transaction is abandoned with no response.

## Timing
- Accept at cycle t. `bus_req_valid` rises at t+1.
- Downstream ready at cycle r. RESP begins at r+1.
- `bus_resp_valid` at cycle s. `mN_resp_valid` is high at s+1 for exactly one cycle, and the FSM is in IDLE at s+1.
- A new accept is possible at s+1, giving a minimum of 3 cycles per transaction with no bubbles beyond that.
- With the timeout: the error pulse arrives `TIMEOUT_CYCLES`+1 cycles after entering RESP.
- `mN_req_ready` is 0 in REQ and RESP. Masters hold their request fields until ready.

## Structure
- Package `bus_arb_pkg` holds:
  - state localparams (IDLE/REQ/RESP) and the 2-bit state width;
  - `BUS_ADDR_WIDTH`=32, `BUS_DATA_WIDTH`=32, `BUS_WMASK_WIDTH`=4.
- Sub-module `rr_arb2` is the combinational two-way round-robin picker.
  - Inputs: `req[1:0]`, `last_grant`.
  - Outputs: `grant[1:0]` (one-hot or zero).

## Test plan
- **Single read:** m0 read at 0x0000_0100; downstream ready immediately; response 0xDEADBEEF 2 cycles later → m0 `resp_valid` one cycle with data 0xDEADBEEF, `err`=0; m1 sees nothing.
- **Contention:** m0 and m1 both valid from reset, each issuing 4 requests → grants alternate 0,1,0,1,…; m1's first accept follows m0's response.
- **Write routing:** m1 write, addr 0x8000_0004, data 0x1234_5678, wmask 4'b0011 → `bus_req_*` carry exactly those values from t+1; `bus_req_ready` held low for 5 cycles → fields stable, `bus_req_valid` high throughout.
- **Timeout:** `TIMEOUT_CYCLES`=8, no `bus_resp_valid` → m0 gets `resp_err`=1, data 0, 9 cycles after entering RESP; a `bus_resp_valid` injected 2 cycles later is ignored.
- **Tie:** `bus_resp_valid` on the exact timeout cycle → `err`=0 and the real data is returned.
- **Mid-transaction reset:** `S_AXI_ARESETN` low while in RESP → all outputs 0 immediately (asynchronous); after release, the next contention grants m0 first.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared constants and types for the two-master bus arbiter.
// Bus widths, FSM state encoding and the timeout counter width helper.
package bus_arb_pkg;

    localparam int unsigned BUS_ADDR_WIDTH  = 32;
    localparam int unsigned BUS_DATA_WIDTH  = 32;
    localparam int unsigned BUS_WMASK_WIDTH = 4;

    localparam int unsigned STATE_WIDTH = 2;

    localparam logic [STATE_WIDTH-1:0] IDLE = 2'd0;
    localparam logic [STATE_WIDTH-1:0] REQ  = 2'd1;
    localparam logic [STATE_WIDTH-1:0] RESP = 2'd2;

    typedef enum logic [STATE_WIDTH-1:0] {
        StIdle = IDLE,
        StReq  = REQ,
        StResp = RESP
    } arb_state_e;

    // A zero limit disables the timeout but the counter still needs one bit to exist.
    function automatic int unsigned cnt_width(input int unsigned limit);
        if (limit == 0) begin
            return 32'd1;
        end
        return int'($clog2(limit + 1));
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/response channel used on both master ports and the downstream bus.
// The initiator drives the request fields; the target drives ready and the response.
interface bus_arbiter_if;
    import bus_arb_pkg::*;

    logic                       req_valid;
    logic                       req_ready;
    logic [BUS_ADDR_WIDTH-1:0]  req_addr;
    logic                       req_wen;
    logic [BUS_WMASK_WIDTH-1:0] req_wmask;
    logic [BUS_DATA_WIDTH-1:0]  req_data;
    logic                       resp_valid;
    logic [BUS_DATA_WIDTH-1:0]  resp_data;
    logic                       resp_err;

    modport master (
        output req_valid, req_addr, req_wen, req_wmask, req_data,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wen, req_wmask, req_data,
        output req_ready, resp_valid, resp_data, resp_err
    );

endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker.
// A lone requester always wins; on a tie the master not granted last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master arbiter for the core-side memory bus with one transaction in flight,
// registered request forwarding, response routing and a downstream timeout.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic           S_AXI_ACLK,
    input logic           S_AXI_ARESETN,
    bus_arbiter_if.slave  m0,
    bus_arbiter_if.slave  m1,
    bus_arbiter_if.master bus
);

    localparam int unsigned     CntW   = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);
    localparam bit              TimeoutEn = (TIMEOUT_CYCLES != 0);

    arb_state_e                      state_q, state_d;
    logic                            owner_q, owner_d;
    logic                            last_grant_q, last_grant_d;
    logic [CntW-1:0]                 cnt_q, cnt_d;
    logic [BUS_ADDR_WIDTH-1:0]       addr_q, addr_d;
    logic                            wen_q, wen_d;
    logic [BUS_WMASK_WIDTH-1:0]      wmask_q, wmask_d;
    logic [BUS_DATA_WIDTH-1:0]       data_q, data_d;
    logic [1:0]                      resp_valid_q, resp_valid_d;
    logic [1:0]                      resp_err_q, resp_err_d;
    logic [1:0][BUS_DATA_WIDTH-1:0]  resp_data_q, resp_data_d;

    logic [1:0] req_vec;
    logic [1:0] grant;
    logic       in_idle;

    assign req_vec = {m1.req_valid, m0.req_valid};
    assign in_idle = (state_q == StIdle);

    rr_arb2 u_rr_arb2 (
        .req        (req_vec),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    // Ready is combinational off the picker; gated by reset so it reads 0 while held in reset.
    assign m0.req_ready = S_AXI_ARESETN & in_idle & grant[0];
    assign m1.req_ready = S_AXI_ARESETN & in_idle & grant[1];

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wen_d        = wen_q;
        wmask_d      = wmask_q;
        data_d       = data_q;
        resp_valid_d = 2'b00;
        resp_err_d   = 2'b00;
        resp_data_d  = '0;

        unique case (state_q)
            StIdle: begin
                if (grant[1]) begin
                    owner_d = 1'b1;
                    addr_d  = m1.req_addr;
                    wen_d   = m1.req_wen;
                    wmask_d = m1.req_wmask;
                    data_d  = m1.req_data;
                    state_d = StReq;
                end else if (grant[0]) begin
                    owner_d = 1'b0;
                    addr_d  = m0.req_addr;
                    wen_d   = m0.req_wen;
                    wmask_d = m0.req_wmask;
                    data_d  = m0.req_data;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (bus.req_ready) begin
                    cnt_d   = '0;
                    state_d = StResp;
                end
            end
            StResp: begin
                // A real response beats a timeout landing in the same cycle.
                if (bus.resp_valid) begin
                    resp_valid_d[owner_q] = 1'b1;
                    resp_data_d[owner_q]  = bus.resp_data;
                    last_grant_d          = owner_q;
                    state_d               = StIdle;
                end else begin
                    if (cnt_q != CntMax) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (TimeoutEn && (cnt_q == CntMax)) begin
                        resp_valid_d[owner_q] = 1'b1;
                        resp_err_d[owner_q]   = 1'b1;
                        last_grant_d          = owner_q;
                        state_d               = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q      <= StIdle;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            wmask_q      <= '0;
            data_q       <= '0;
            resp_valid_q <= 2'b00;
            resp_err_q   <= 2'b00;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wen_q        <= wen_d;
            wmask_q      <= wmask_d;
            data_q       <= data_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign bus.req_valid = (state_q == StReq);
    assign bus.req_addr  = addr_q;
    assign bus.req_wen   = wen_q;
    assign bus.req_wmask = wmask_q;
    assign bus.req_data  = data_q;

    assign m0.resp_valid = resp_valid_q[0];
    assign m0.resp_err   = resp_err_q[0];
    assign m0.resp_data  = resp_data_q[0];
    assign m1.resp_valid = resp_valid_q[1];
    assign m1.resp_err   = resp_err_q[1];
    assign m1.resp_data  = resp_data_q[1];

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter: contention, routing, timeout, tie, reset.
module tb_bus_arbiter;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    bus_arbiter_if m0_if ();
    bus_arbiter_if m1_if ();
    bus_arbiter_if bus_if ();

    bus_arbiter #(
        .TIMEOUT_CYCLES (8)
    ) u_dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .m0            (m0_if),
        .m1            (m1_if),
        .bus           (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rdy(input int w);
        return (w == 1) ? m1_if.req_ready : m0_if.req_ready;
    endfunction

    function automatic logic rvld(input int w);
        return (w == 1) ? m1_if.resp_valid : m0_if.resp_valid;
    endfunction

    function automatic logic [31:0] rdat(input int w);
        return (w == 1) ? m1_if.resp_data : m0_if.resp_data;
    endfunction

    function automatic logic rerr(input int w);
        return (w == 1) ? m1_if.resp_err : m0_if.resp_err;
    endfunction

    task automatic set_req(input int w, input logic v, input logic [31:0] addr,
                           input logic wen, input logic [3:0] wmask, input logic [31:0] data);
        if (w == 1) begin
            m1_if.req_valid = v; m1_if.req_addr = addr; m1_if.req_wen = wen;
            m1_if.req_wmask = wmask; m1_if.req_data = data;
        end else begin
            m0_if.req_valid = v; m0_if.req_addr = addr; m0_if.req_wen = wen;
            m0_if.req_wmask = wmask; m0_if.req_data = data;
        end
    endtask

    task automatic set_valid(input int w, input logic v);
        if (w == 1) m1_if.req_valid = v;
        else        m0_if.req_valid = v;
    endtask

    // One read transaction with immediate downstream ready and response one cycle into RESP.
    task automatic run_txn(input int w, input logic [31:0] addr, input logic [31:0] rdata,
                           input bit drop);
        check("ready_winner", 32'(rdy(w)), 32'd1);
        check("ready_loser", 32'(rdy(1 - w)), 32'd0);
        tick();
        if (drop) set_valid(w, 1'b0);
        check("bus_req_valid", 32'(bus_if.req_valid), 32'd1);
        check("bus_req_addr", bus_if.req_addr, addr);
        check("ready_in_req", 32'(rdy(w)), 32'd0);
        bus_if.req_ready = 1'b1;
        tick();
        bus_if.req_ready  = 1'b0;
        bus_if.resp_valid = 1'b1;
        bus_if.resp_data  = rdata;
        tick();
        bus_if.resp_valid = 1'b0;
        check("resp_valid_owner", 32'(rvld(w)), 32'd1);
        check("resp_data_owner", rdat(w), rdata);
        check("resp_err_owner", 32'(rerr(w)), 32'd0);
        check("resp_valid_other", 32'(rvld(1 - w)), 32'd0);
    endtask

    task automatic enter_resp_m0(input logic [31:0] addr);
        set_req(0, 1'b1, addr, 1'b0, 4'h0, 32'h0);
        #1;
        check("to_ready", 32'(m0_if.req_ready), 32'd1);
        tick();
        set_valid(0, 1'b0);
        bus_if.req_ready = 1'b1;
        tick();
        bus_if.req_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        set_req(0, 1'b1, 32'h0000_0100, 1'b0, 4'h0, 32'h0);
        set_req(1, 1'b1, 32'h0000_0200, 1'b0, 4'h0, 32'h0);
        bus_if.req_ready  = 1'b0;
        bus_if.resp_valid = 1'b0;
        bus_if.resp_data  = 32'h0;
        bus_if.resp_err   = 1'b0;

        // Held in reset with both masters requesting: every output stays 0.
        tick();
        tick();
        check("rst_m0_ready", 32'(m0_if.req_ready), 32'd0);
        check("rst_m1_ready", 32'(m1_if.req_ready), 32'd0);
        check("rst_bus_valid", 32'(bus_if.req_valid), 32'd0);
        check("rst_bus_addr", bus_if.req_addr, 32'h0);
        check("rst_m0_resp", 32'(m0_if.resp_valid), 32'd0);
        check("rst_m1_resp", 32'(m1_if.resp_valid), 32'd0);

        // Contention from reset: grants alternate starting with m0, 4 requests each.
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            run_txn(i % 2, (i % 2 == 1) ? 32'h0000_0200 : 32'h0000_0100,
                    32'hA000_0000 + 32'(i), i >= 6);
        end
        check("cont_idle_m0", 32'(m0_if.req_ready), 32'd0);
        check("cont_idle_m1", 32'(m1_if.req_ready), 32'd0);

        // Single read with the response two cycles after downstream ready.
        set_req(0, 1'b1, 32'h0000_0100, 1'b0, 4'h0, 32'h0);
        #1;
        check("sr_ready", 32'(m0_if.req_ready), 32'd1);
        tick();
        set_valid(0, 1'b0);
        check("sr_bus_addr", bus_if.req_addr, 32'h0000_0100);
        check("sr_bus_wen", 32'(bus_if.req_wen), 32'd0);
        bus_if.req_ready = 1'b1;
        tick();
        bus_if.req_ready = 1'b0;
        tick();
        check("sr_no_early_resp", 32'(m0_if.resp_valid), 32'd0);
        bus_if.resp_valid = 1'b1;
        bus_if.resp_data  = 32'hDEAD_BEEF;
        tick();
        bus_if.resp_valid = 1'b0;
        check("sr_resp_valid", 32'(m0_if.resp_valid), 32'd1);
        check("sr_resp_data", m0_if.resp_data, 32'hDEAD_BEEF);
        check("sr_resp_err", 32'(m0_if.resp_err), 32'd0);
        check("sr_m1_quiet", 32'(m1_if.resp_valid), 32'd0);
        tick();
        check("sr_one_cycle", 32'(m0_if.resp_valid), 32'd0);

        // Write from m1: fields latched and held while downstream stalls.
        set_req(1, 1'b1, 32'h8000_0004, 1'b1, 4'b0011, 32'h1234_5678);
        #1;
        check("wr_ready_m1", 32'(m1_if.req_ready), 32'd1);
        check("wr_ready_m0", 32'(m0_if.req_ready), 32'd0);
        tick();
        set_req(1, 1'b0, 32'hFFFF_FFFF, 1'b0, 4'hF, 32'hFFFF_FFFF);
        for (int k = 0; k < 5; k++) begin
            check("wr_bus_valid", 32'(bus_if.req_valid), 32'd1);
            check("wr_bus_addr", bus_if.req_addr, 32'h8000_0004);
            check("wr_bus_wen", 32'(bus_if.req_wen), 32'd1);
            check("wr_bus_wmask", 32'(bus_if.req_wmask), 32'h3);
            check("wr_bus_data", bus_if.req_data, 32'h1234_5678);
            tick();
        end
        bus_if.req_ready = 1'b1;
        tick();
        bus_if.req_ready = 1'b0;
        check("wr_bus_valid_drop", 32'(bus_if.req_valid), 32'd0);
        bus_if.resp_valid = 1'b1;
        bus_if.resp_data  = 32'h0;
        tick();
        bus_if.resp_valid = 1'b0;
        check("wr_resp_valid", 32'(m1_if.resp_valid), 32'd1);
        check("wr_resp_err", 32'(m1_if.resp_err), 32'd0);
        check("wr_m0_quiet", 32'(m0_if.resp_valid), 32'd0);

        // Timeout: error pulse 9 cycles after entering RESP; a late response is dropped.
        enter_resp_m0(32'h0000_0300);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("to_no_pulse", 32'(m0_if.resp_valid), 32'd0);
        end
        tick();
        check("to_resp_valid", 32'(m0_if.resp_valid), 32'd1);
        check("to_resp_err", 32'(m0_if.resp_err), 32'd1);
        check("to_resp_data", m0_if.resp_data, 32'h0);
        check("to_m1_quiet", 32'(m1_if.resp_valid), 32'd0);
        tick();
        tick();
        bus_if.resp_valid = 1'b1;
        bus_if.resp_data  = 32'h0000_0BAD;
        tick();
        bus_if.resp_valid = 1'b0;
        check("to_late_m0", 32'(m0_if.resp_valid), 32'd0);
        check("to_late_m1", 32'(m1_if.resp_valid), 32'd0);
        tick();
        check("to_late_m0_2", 32'(m0_if.resp_valid), 32'd0);

        // Tie: response on the exact timeout cycle wins.
        enter_resp_m0(32'h0000_0400);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("tie_no_pulse", 32'(m0_if.resp_valid), 32'd0);
        end
        bus_if.resp_valid = 1'b1;
        bus_if.resp_data  = 32'h5A5A_1234;
        tick();
        bus_if.resp_valid = 1'b0;
        check("tie_resp_valid", 32'(m0_if.resp_valid), 32'd1);
        check("tie_resp_err", 32'(m0_if.resp_err), 32'd0);
        check("tie_resp_data", m0_if.resp_data, 32'h5A5A_1234);

        // Reset while in RESP: outputs clear at once, then m0 wins the next contention.
        enter_resp_m0(32'h0000_0600);
        check("mr_latched_addr", bus_if.req_addr, 32'h0000_0600);
        set_req(0, 1'b1, 32'h0000_0100, 1'b0, 4'h0, 32'h0);
        set_req(1, 1'b1, 32'h0000_0200, 1'b0, 4'h0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_bus_addr", bus_if.req_addr, 32'h0);
        check("mr_bus_valid", 32'(bus_if.req_valid), 32'd0);
        check("mr_m0_ready", 32'(m0_if.req_ready), 32'd0);
        check("mr_m1_ready", 32'(m1_if.req_ready), 32'd0);
        bus_if.resp_valid = 1'b1;
        bus_if.resp_data  = 32'h7777_7777;
        tick();
        tick();
        bus_if.resp_valid = 1'b0;
        check("mr_m0_resp", 32'(m0_if.resp_valid), 32'd0);
        check("mr_m1_resp", 32'(m1_if.resp_valid), 32'd0);
        rst_n = 1'b1;
        #1;
        run_txn(0, 32'h0000_0100, 32'hC0DE_0001, 1'b0);
        set_valid(0, 1'b0);
        set_valid(1, 1'b0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
